// File: rtl/sequencer.sv
// rtl/sequencer.sv - microcode sequencer: T-state counter, opcode shadow, ROM address
//
// Ports:
//   clk          in   1                rising-edge clock
//   reset_bar    in   1                asynchronous active-low reset
//   ir_opcode    in   OP_BITS          IR opcode byte, captured at the last fetch step
//   rt_bar       in   1                active-low end-of-instruction microcode bit
//   halt         in   1                freezes all state while high
//   tstate       out  T_BITS           current T-state
//   fetch        out  1                high during the shared fetch T-states
//   uaddr        out  OP_BITS+T_BITS   microcode ROM address
//   instr_count  out  16               retired-instruction counter (wraps)
//   wrap_err     out  1                sticky: T-state ran off the end without rt

module sequencer #(
    parameter int T_BITS      = 3,
    parameter int OP_BITS     = 8,
    parameter int FETCH_STEPS = 2
) (
    input  logic                      clk,
    input  logic                      reset_bar,
    input  logic [OP_BITS-1:0]        ir_opcode,
    input  logic                      rt_bar,
    input  logic                      halt,
    output logic [T_BITS-1:0]         tstate,
    output logic                      fetch,
    output logic [OP_BITS+T_BITS-1:0] uaddr,
    output logic [15:0]               instr_count,
    output logic                      wrap_err
);

    localparam logic [T_BITS-1:0] T_LAST     = {T_BITS{1'b1}};
    localparam logic [T_BITS-1:0] FETCH_N    = T_BITS'(FETCH_STEPS);
    localparam logic [T_BITS-1:0] FETCH_LAST = T_BITS'(FETCH_STEPS - 1);

    logic [OP_BITS-1:0] op_q;
    logic [T_BITS-1:0]  tstate_nxt;
    logic [OP_BITS-1:0] op_nxt;
    logic [15:0]        count_nxt;
    logic               wrap_nxt;

    // Priority: halt freezes everything, then rt, then overflow, then increment.
    always_comb begin
        tstate_nxt = tstate;
        op_nxt     = op_q;
        count_nxt  = instr_count;
        wrap_nxt   = wrap_err;
        if (!halt) begin
            if (!rt_bar) begin
                // rt on the last fetch step aborts without capturing the opcode
                tstate_nxt = '0;
                count_nxt  = instr_count + 16'd1;
            end else begin
                // capture at the end of fetch so IR reloading cannot glitch uaddr
                if (tstate == FETCH_LAST) begin
                    op_nxt = ir_opcode;
                end
                if (tstate == T_LAST) begin
                    tstate_nxt = '0;
                    wrap_nxt   = 1'b1;
                    count_nxt  = instr_count + 16'd1;
                end else begin
                    tstate_nxt = tstate + T_BITS'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            tstate      <= '0;
            op_q        <= '0;
            instr_count <= '0;
            wrap_err    <= 1'b0;
        end else begin
            tstate      <= tstate_nxt;
            op_q        <= op_nxt;
            instr_count <= count_nxt;
            wrap_err    <= wrap_nxt;
        end
    end

    // Outputs decode from registers only; fetch steps all share opcode 0.
    assign fetch = (tstate < FETCH_N);
    assign uaddr = fetch ? {{OP_BITS{1'b0}}, tstate} : {op_q, tstate};

endmodule

// File: tb/tb_sequencer.sv
// tb/tb_sequencer.sv - scoreboard testbench for sequencer

module tb_sequencer;

    localparam int TB  = 3;
    localparam int OB  = 8;
    localparam int FS  = 2;
    localparam int TMAX = (1 << TB) - 1;

    logic               clk = 1'b0;
    logic               reset_bar;
    logic [OB-1:0]      ir_opcode;
    logic               rt_bar;
    logic               halt;
    logic [TB-1:0]      tstate;
    logic               fetch;
    logic [OB+TB-1:0]   uaddr;
    logic [15:0]        instr_count;
    logic               wrap_err;

    sequencer #(.T_BITS(TB), .OP_BITS(OB), .FETCH_STEPS(FS)) dut (
        .clk(clk),
        .reset_bar(reset_bar),
        .ir_opcode(ir_opcode),
        .rt_bar(rt_bar),
        .halt(halt),
        .tstate(tstate),
        .fetch(fetch),
        .uaddr(uaddr),
        .instr_count(instr_count),
        .wrap_err(wrap_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int t;
        int f;
        int ua;
        int cnt;
        int we;
    } exp_s;

    exp_s q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // reference state
    int m_t, m_op, m_cnt, m_we;

    function automatic exp_s model_out();
        exp_s e;
        e.t   = m_t;
        e.f   = (m_t < FS) ? 1 : 0;
        e.ua  = (m_t < FS) ? m_t : (m_op * (1 << TB) + m_t);
        e.cnt = m_cnt;
        e.we  = m_we;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare(input string tag, input exp_s e);
        chk({tag, ".tstate"},      int'(tstate),      e.t);
        chk({tag, ".fetch"},       int'(fetch),       e.f);
        chk({tag, ".uaddr"},       int'(uaddr),       e.ua);
        chk({tag, ".instr_count"}, int'(instr_count), e.cnt);
        chk({tag, ".wrap_err"},    int'(wrap_err),    e.we);
    endtask

    task automatic model_reset();
        m_t = 0; m_op = 0; m_cnt = 0; m_we = 0;
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, queue result.
    task automatic step(input logic h, input logic r, input logic [OB-1:0] opc);
        halt = h; rt_bar = r; ir_opcode = opc;
        @(posedge clk);
        #1;
        if (!h) begin
            if (!r) begin
                m_t = 0;
                m_cnt = (m_cnt + 1) % 65536;
            end else begin
                if (m_t == FS - 1) m_op = int'(opc);
                if (m_t == TMAX) begin
                    m_t = 0;
                    m_we = 1;
                    m_cnt = (m_cnt + 1) % 65536;
                end else begin
                    m_t = m_t + 1;
                end
            end
        end
        q.push_back(model_out());
    endtask

    // Reset pulse between edges; outputs must clear without a clock.
    task automatic pulse_reset();
        @(negedge clk);
        #1 reset_bar = 1'b0;
        #1;
        model_reset();
        compare("async_reset", model_out());
        #1 reset_bar = 1'b1;
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            compare("mon", q.pop_front());
        end
    end

    initial begin
        reset_bar = 1'b0;
        halt = 1'b0;
        rt_bar = 1'b1;
        ir_opcode = 8'h9D;
        model_reset();
        #2;
        compare("reset", model_out());
        chk("reset.uaddr_const", int'(uaddr), 0);
        chk("reset.fetch_const", int'(fetch), 1);
        @(negedge clk);
        reset_bar = 1'b1;

        // fetch/exec addressing: T1, then T2 with opcode 0x9D
        step(0, 1, 8'h9D);
        step(0, 1, 8'h9D);
        #1 chk("t2.uaddr_4EA", int'(uaddr), 'h4EA);
        // end of instruction at T3
        step(0, 1, 8'h9D);
        step(0, 0, 8'h9D);
        #1 chk("rt.count_1", int'(instr_count), 1);

        // halt at T2 for 3 clocks with rt on the 2nd, then resume to T3
        step(0, 1, 8'h55);
        step(0, 1, 8'h9D);
        step(1, 1, 8'h9D);
        step(1, 0, 8'h9D);
        step(1, 1, 8'h9D);
        step(0, 1, 8'h9D);
        #1 chk("halt.resume_t3", int'(tstate), 3);

        // overflow from T0: 8 clocks without rt
        step(0, 0, 8'h9D);
        for (int i = 0; i < 8; i++) step(0, 1, 8'h9D);
        #1 chk("wrap.err_set", int'(wrap_err), 1);
        step(0, 1, 8'h9D);
        step(0, 0, 8'h9D);
        #1 chk("wrap.err_sticky", int'(wrap_err), 1);

        // rt at the final fetch step aborts without capture
        step(0, 1, 8'h9D);
        step(0, 0, 8'h33);
        step(0, 1, 8'h44);
        step(0, 1, 8'h9D);
        #1 chk("abort.op_kept", int'(uaddr), 'h9D * 8 + 2);

        // opcode isolation during execute, then async reset at T4
        step(0, 0, 8'h9D);
        step(0, 1, 8'h9D);
        step(0, 1, 8'h9D);
        step(0, 1, 8'h12);
        step(0, 1, 8'h12);
        #1 chk("iso.uaddr_t4", int'(uaddr), 'h9D * 8 + 4);
        pulse_reset();

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 4) == 0), ($urandom_range(0, 3) != 0),
                 8'($urandom));
        end

        // counter wrap: mostly single-cycle rt, last three via rt at T2
        pulse_reset();
        for (int i = 0; i < 65533; i++) step(0, 0, 8'($urandom));
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 8'hA5);
            step(0, 1, 8'hA5);
            if (k == 2) begin
                #1 chk("wrap16.ffff", int'(instr_count), 'hFFFF);
            end
            step(0, 0, 8'hA5);
        end
        #1 chk("wrap16.zero", int'(instr_count), 0);

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
